// File: rtl/bcd_divisibility_seq.sv
// rtl/bcd_divisibility_seq.sv - sequential BCD divisibility checker, MSD-first Horner remainder
// One digit per clock; results are registered and announced by a one-cycle o_valid.
module bcd_divisibility_seq #(
  parameter int DIGITS = 8,
  parameter int DIV_W  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [4*DIGITS-1:0]   i_input,
  input  logic [DIV_W-1:0]      i_divisor,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic                  o_output,
  output logic [DIV_W-1:0]      o_rem,
  output logic                  o_invalid,
  output logic                  o_err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [4*DIGITS-1:0]  r_operand;
  logic [DIV_W-1:0]     r_div;
  logic [DIV_W-1:0]     r_rem;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_inv;
  logic                 r_err;

  logic                 w_accept;
  logic [3:0]           w_digit;
  logic [DIV_W+3:0]     w_acc;
  logic [DIV_W-1:0]     w_rem_next;

  assign w_accept = (r_state == S_IDLE) && i_start;

  // The operand shifts left each RUN cycle, so the current digit is always the top nibble.
  assign w_digit = r_operand[4*DIGITS-1 -: 4];
  assign w_acc   = {1'b0, r_rem, 3'b000} + {3'b000, r_rem, 1'b0} + {{DIV_W{1'b0}}, w_digit};
  assign w_rem_next = (r_div == '0) ? '0 : DIV_W'(w_acc % {4'b0000, r_div});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (i_divisor == '0) ? S_DONE : S_RUN;
      S_RUN:   if (r_idx == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_operand <= '0;
      r_div     <= '0;
      r_rem     <= '0;
      r_idx     <= '0;
      r_inv     <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_operand <= i_input;
      r_div     <= i_divisor;
      r_rem     <= '0;
      r_idx     <= IDX_W'(DIGITS - 1);
      r_inv     <= 1'b0;
      r_err     <= (i_divisor == '0);
    end else if (r_state == S_RUN) begin
      // Non-BCD nibbles flag INVALID but still feed the arithmetic unchanged.
      r_rem     <= w_rem_next;
      r_inv     <= r_inv | (w_digit > 4'd9);
      r_operand <= r_operand << 4;
      if (r_idx != '0) r_idx <= r_idx - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_output  <= 1'b0;
      o_rem     <= '0;
      o_invalid <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_valid <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        o_rem     <= r_rem;
        o_output  <= (r_rem == '0) && !r_inv && !r_err;
        o_invalid <= r_inv;
        o_err     <= r_err;
      end
    end
  end

endmodule

// File: tb/tb_bcd_divisibility_seq.sv
// tb/tb_bcd_divisibility_seq.sv - self-checking bench for bcd_divisibility_seq
// Expected results come from an arithmetic model: operand value = sum(nibble * 10^i), then mod D.
module tb_bcd_divisibility_seq;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [15:0] i_input;
  logic [3:0]  i_divisor;
  logic        o_ready, o_valid, o_output, o_invalid, o_err;
  logic [3:0]  o_rem;

  logic        s8_start;
  logic [31:0] s8_input;
  logic [3:0]  s8_divisor;
  logic        s8_ready, s8_valid, s8_output, s8_invalid, s8_err;
  logic [3:0]  s8_rem;

  int errors = 0;
  int checks = 0;

  bcd_divisibility_seq #(.DIGITS(4), .DIV_W(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_input(i_input), .i_divisor(i_divisor),
    .o_ready(o_ready), .o_valid(o_valid), .o_output(o_output), .o_rem(o_rem),
    .o_invalid(o_invalid), .o_err(o_err)
  );

  bcd_divisibility_seq #(.DIGITS(8), .DIV_W(4)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8_start), .i_input(s8_input), .i_divisor(s8_divisor),
    .o_ready(s8_ready), .o_valid(s8_valid), .o_output(s8_output), .o_rem(s8_rem),
    .o_invalid(s8_invalid), .o_err(s8_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [31:0] v, input int nd, input int d,
                                output int rem, output bit outp, output bit inv, output bit err);
    longint val = 0;
    longint p = 1;
    logic [3:0] nib;
    inv = 0;
    for (int i = 0; i < nd; i++) begin
      nib = v[i*4 +: 4];
      val = val + longint'(nib) * p;
      p = p * 10;
      if (nib > 4'd9) inv = 1;
    end
    err  = (d == 0);
    rem  = (d == 0) ? 0 : int'(val % longint'(d));
    outp = (rem == 0) && !inv && !err;
  endfunction

  // Issues one operation on the 4-digit DUT and returns what it reported and when.
  task automatic do_op(input logic [15:0] in, input logic [3:0] d, output int lat,
                       output int rem, output bit outp, output bit inv, output bit err);
    @(negedge clk);
    i_input = in; i_divisor = d; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    i_input = 16'($urandom); i_divisor = 4'($urandom);
    lat = -1; rem = -1; outp = 0; inv = 0; err = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        lat = n; rem = int'(o_rem); outp = o_output; inv = o_invalid; err = o_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (o_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    checks++; if (o_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_output !== 1'b0)  begin errors++; $display("FAIL reset_output got=%b exp=0", o_output); end
    checks++; if (o_rem !== 4'd0)     begin errors++; $display("FAIL reset_rem got=%0d exp=0", o_rem); end
    checks++; if (o_invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got=%b exp=0", o_invalid); end
    checks++; if (o_err !== 1'b0)     begin errors++; $display("FAIL reset_err got=%b exp=0", o_err); end
  endtask

  task automatic test_directed;
    logic [15:0] ins  [5] = '{16'h0033, 16'h9998, 16'h9999, 16'h12A4, 16'h0012};
    logic [3:0]  divs [5] = '{4'd11, 4'd11, 4'd9, 4'd3, 4'd3};
    int          erem [5] = '{0, 10, 0, 2, 0};
    bit          eout [5] = '{1, 0, 1, 0, 1};
    bit          einv [5] = '{0, 0, 0, 1, 0};
    int lat, rem; bit outp, inv, err;
    for (int i = 0; i < 5; i++) begin
      do_op(ins[i], divs[i], lat, rem, outp, inv, err);
      checks++; if (lat != 5)        begin errors++; $display("FAIL dir%0d_latency got=%0d exp=5", i, lat); end
      checks++; if (rem != erem[i])  begin errors++; $display("FAIL dir%0d_rem got=%0d exp=%0d", i, rem, erem[i]); end
      checks++; if (outp != eout[i]) begin errors++; $display("FAIL dir%0d_output got=%b exp=%b", i, outp, eout[i]); end
      checks++; if (inv != einv[i])  begin errors++; $display("FAIL dir%0d_invalid got=%b exp=%b", i, inv, einv[i]); end
      checks++; if (err != 1'b0)     begin errors++; $display("FAIL dir%0d_err got=%b exp=0", i, err); end
    end
  endtask

  task automatic test_div_zero;
    int lat, rem; bit outp, inv, err;
    do_op(16'h0909, 4'd0, lat, rem, outp, inv, err);
    checks++; if (lat != 1)   begin errors++; $display("FAIL divzero_latency got=%0d exp=1", lat); end
    checks++; if (err != 1)   begin errors++; $display("FAIL divzero_err got=%b exp=1", err); end
    checks++; if (outp != 0)  begin errors++; $display("FAIL divzero_output got=%b exp=0", outp); end
    checks++; if (rem != 0)   begin errors++; $display("FAIL divzero_rem got=%0d exp=0", rem); end
    do_op(16'h0042, 4'd1, lat, rem, outp, inv, err);
    checks++; if (rem != 0 || outp != 1 || err != 0)
      begin errors++; $display("FAIL div1 got rem=%0d out=%b err=%b exp rem=0 out=1 err=0", rem, outp, err); end
  endtask

  task automatic test_random;
    logic [15:0] in; logic [3:0] d;
    int lat, rem, erem; bit outp, inv, err, eout, einv, eerr;
    for (int t = 0; t < 30; t++) begin
      in = 16'($urandom);
      if (t % 3 != 0)
        for (int k = 0; k < 4; k++) in[k*4 +: 4] = 4'($urandom_range(0, 9));
      d = 4'($urandom_range(0, 15));
      model({16'h0, in}, 4, int'(d), erem, eout, einv, eerr);
      do_op(in, d, lat, rem, outp, inv, err);
      checks++;
      if (lat != (d == 0 ? 1 : 5) || rem != erem || outp != eout || inv != einv || err != eerr) begin
        errors++;
        $display("FAIL rand%0d in=%h d=%0d got lat=%0d rem=%0d out=%b inv=%b err=%b exp lat=%0d rem=%0d out=%b inv=%b err=%b",
                 t, in, d, lat, rem, outp, inv, err, (d == 0 ? 1 : 5), erem, eout, einv, eerr);
      end
    end
  endtask

  task automatic test_hold;
    int lat, rem; bit outp, inv, err;
    do_op(16'h9998, 4'd11, lat, rem, outp, inv, err);
    @(negedge clk);
    i_input = 16'h0033; i_divisor = 4'd11; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_run got=%b exp=0", o_ready); end
    @(posedge clk); #1;
    checks++; if (o_rem !== 4'd10 || o_output !== 1'b0)
      begin errors++; $display("FAIL hold_results got rem=%0d out=%b exp rem=10 out=0", o_rem, o_output); end
    lat = -1;
    for (int n = 3; n <= 20; n++) begin
      @(posedge clk); #1;
      if (o_valid) begin lat = n; break; end
    end
    checks++; if (lat != 5 || o_rem !== 4'd0 || o_output !== 1'b1)
      begin errors++; $display("FAIL hold_new got lat=%0d rem=%0d out=%b exp lat=5 rem=0 out=1", lat, o_rem, o_output); end
    @(posedge clk); #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width got=%b exp=0", o_valid); end
  endtask

  task automatic test_ignored_start;
    int nvalid = 0; int vrem = -1;
    @(negedge clk);
    i_input = 16'h0033; i_divisor = 4'd11; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin i_start = 1'b1; i_input = 16'h9998; i_divisor = 4'd11; end
      if (n == 2) i_start = 1'b0;
      if (o_valid) begin nvalid++; vrem = int'(o_rem); end
    end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL ignored_start_count got=%0d exp=1", nvalid); end
    checks++; if (vrem != 0)   begin errors++; $display("FAIL ignored_start_rem got=%0d exp=0", vrem); end
  endtask

  task automatic test_back_to_back;
    int vedge[$]; int vrem[$];
    @(negedge clk);
    i_input = 16'h9998; i_divisor = 4'd11; i_start = 1'b1;
    for (int n = 0; n <= 30; n++) begin
      @(posedge clk); #1;
      if (o_valid) begin vedge.push_back(n); vrem.push_back(int'(o_rem)); end
      if (vedge.size() == 2) break;
    end
    i_start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (vedge.size() != 2) begin
      errors++; $display("FAIL b2b_count got=%0d exp=2", vedge.size());
    end else if (vedge[1] - vedge[0] != 6 || vedge[0] != 5 || vrem[0] != 10 || vrem[1] != 10) begin
      errors++;
      $display("FAIL b2b_timing got first=%0d gap=%0d rem=%0d/%0d exp first=5 gap=6 rem=10/10",
               vedge[0], vedge[1] - vedge[0], vrem[0], vrem[1]);
    end
  endtask

  task automatic test_reset_mid_run;
    int nvalid = 0;
    @(negedge clk);
    i_input = 16'h0035; i_divisor = 4'd7; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_output !== 1'b0 || o_rem !== 4'd0 || o_invalid !== 1'b0 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset got ready=%b valid=%b out=%b rem=%0d inv=%b err=%b exp 1 0 0 0 0 0",
               o_ready, o_valid, o_output, o_rem, o_invalid, o_err);
    end
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (o_valid) nvalid++;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL midrun_no_valid got=%0d exp=0", nvalid); end
  endtask

  task automatic test_digits8;
    int lat = -1; int rem = -1; bit outp = 1;
    int erem; bit eout, einv, eerr;
    model(32'h12345678, 8, 7, erem, eout, einv, eerr);
    @(negedge clk);
    s8_input = 32'h12345678; s8_divisor = 4'd7; s8_start = 1'b1;
    @(posedge clk); #1 s8_start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (s8_valid) begin lat = n; rem = int'(s8_rem); outp = s8_output; break; end
    end
    checks++; if (lat != 9)     begin errors++; $display("FAIL d8_latency got=%0d exp=9", lat); end
    checks++; if (rem != erem)  begin errors++; $display("FAIL d8_rem got=%0d exp=%0d", rem, erem); end
    checks++; if (outp != eout) begin errors++; $display("FAIL d8_output got=%b exp=%b", outp, eout); end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_input = '0; i_divisor = '0;
    s8_start = 1'b0; s8_input = '0; s8_divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_hold();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_run();
    test_digits8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
